uart_rx_param: RTL and testbench

// - Parametrised, oversampling UART receiver. It generalises the current uart_rx with configurable data

---
 rtl/uart_rx_param.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with parity, stop-bit count and break detection
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority sampling around each bit centre.
module uart_rx_param #(
    parameter int DBIT      = 8,
    parameter int S_TICK    = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            rx_frame_error,
    output logic            rx_parity_error,
    output logic            rx_break
);
    localparam int TW = $clog2(S_TICK);
    localparam int BW = $clog2(DBIT + 1);
`ifdef UART_RX_MAJORITY_EN
    // One extra tick on the start check shifts every later decision to centre+1.
    localparam int START_LAST = S_TICK / 2;
`else
    localparam int START_LAST = S_TICK / 2 - 1;
`endif
    localparam logic [TW-1:0] TICK_MID  = TW'(START_LAST);
    localparam logic [TW-1:0] TICK_LAST = TW'(S_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            ferr_q, ferr_d;
    logic            sone_q, sone_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            fe_q, fe_d;
    logic            pe_q, pe_d;
    logic            brk_q, brk_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            samp;
    logic            par_x;

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign samp = rx_s;
`endif

    assign par_x = ^{shreg_q, par_q};

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        sone_d  = sone_q;
        data_d  = data_q;
        done_d  = 1'b0;
        fe_d    = fe_q;
        pe_d    = pe_q;
        brk_d   = brk_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    tick_d  = '0;
                    bit_d   = '0;
                    par_d   = 1'b0;
                    ferr_d  = 1'b0;
                    sone_d  = 1'b0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = samp ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shreg_d = {samp, shreg_q[DBIT-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        par_d   = samp;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        ferr_d = ferr_q | ~samp;
                        sone_d = sone_q | samp;
                        if (bit_q == STOP_LAST) begin
                            bit_d   = '0;
                            state_d = ST_IDLE;
                            data_d  = shreg_q;
                            done_d  = 1'b1;
                            fe_d    = ferr_q | ~samp;
                            pe_d    = (PARITY == 0) ? 1'b0 : ((PARITY == 1) ? ~par_x : par_x);
                            // Break needs every line sample low, stop bits included.
                            brk_d   = (shreg_q == '0) && !par_q && !(sone_q | samp);
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            sone_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            sone_q  <= sone_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            brk_q   <= brk_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q <= 2'b11;
        end else if (s_tick) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end
`endif

    assign rx_data         = data_q;
    assign rx_done         = done_q;
    assign rx_frame_error  = fe_q;
    assign rx_parity_error = pe_q;
    assign rx_break        = brk_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (default, even-parity, two-stop builds)
module tb_uart_rx_param;
    localparam int ST = 16;

    logic clk = 1'b0;
    logic reset_n, s_tick;
    logic rx_def, rx_par, rx_stp;
    logic [7:0] data_def, data_par, data_stp;
    logic done_def, done_par, done_stp;
    logic fe_def, fe_par, fe_stp, pe_def, pe_par, pe_stp, brk_def, brk_par, brk_stp;

    always #5 clk = ~clk;

    uart_rx_param u_def (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_def),
        .rx_data(data_def), .rx_done(done_def), .rx_frame_error(fe_def),
        .rx_parity_error(pe_def), .rx_break(brk_def));
    uart_rx_param #(.PARITY(2)) u_par (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_par),
        .rx_data(data_par), .rx_done(done_par), .rx_frame_error(fe_par),
        .rx_parity_error(pe_par), .rx_break(brk_par));
    uart_rx_param #(.STOP_BITS(2)) u_stp (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_stp),
        .rx_data(data_stp), .rx_done(done_stp), .rx_frame_error(fe_stp),
        .rx_parity_error(pe_stp), .rx_break(brk_stp));

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       brk;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       pb;
        logic [1:0] stops;
        exp_t       e;
    } vec_t;

    exp_t q_def[$];
    exp_t q_par[$];
    exp_t q_stp[$];
    int total = 0;
    int bad = 0;
    int n_done[3] = '{0, 0, 0};
    int n_exp[3] = '{0, 0, 0};
    logic [2:0] prev_done = 3'b000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int w, input exp_t e);
        case (w)
            0: q_def.push_back(e);
            1: q_par.push_back(e);
            default: q_stp.push_back(e);
        endcase
        n_exp[w]++;
    endtask

    task automatic on_done(input int w, input logic [7:0] d, input logic fe, input logic pe, input logic brk);
        exp_t e;
        logic got;
        got = 1'b0;
        case (w)
            0: if (q_def.size() > 0) begin e = q_def.pop_front(); got = 1'b1; end
            1: if (q_par.size() > 0) begin e = q_par.pop_front(); got = 1'b1; end
            default: if (q_stp.size() > 0) begin e = q_stp.pop_front(); got = 1'b1; end
        endcase
        n_done[w]++;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL dut%0d unexpected rx_done: data %h, none expected", w, d);
        end else begin
            chk($sformatf("dut%0d data", w), 16'(d), 16'(e.d));
            chk($sformatf("dut%0d frame_error", w), 16'(fe), 16'(e.fe));
            chk($sformatf("dut%0d parity_error", w), 16'(pe), 16'(e.pe));
            chk($sformatf("dut%0d break", w), 16'(brk), 16'(e.brk));
        end
    endtask

    always @(negedge clk) begin
        if (done_def) on_done(0, data_def, fe_def, pe_def, brk_def);
        if (done_par) on_done(1, data_par, fe_par, pe_par, brk_par);
        if (done_stp) on_done(2, data_stp, fe_stp, pe_stp, brk_stp);
        if ((prev_done & {done_stp, done_par, done_def}) != 3'b000) begin
            total++;
            bad++;
            $display("FAIL rx_done width: high two clk in a row, mask %b", prev_done & {done_stp, done_par, done_def});
        end
        prev_done = {done_stp, done_par, done_def};
    end

    task automatic drive(input int w, input logic v, input int n);
        case (w)
            0: rx_def = v;
            1: rx_par = v;
            default: rx_stp = v;
        endcase
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input logic has_par, input logic pb,
                              input logic [1:0] stops, input int nstop, input int gbit);
        drive(w, 1'b0, ST);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                drive(w, d[i], ST / 2);
                drive(w, ~d[i], 1);
                drive(w, d[i], ST / 2 - 1);
            end else begin
                drive(w, d[i], ST);
            end
        end
        if (has_par) drive(w, pb, ST);
        for (int s = 0; s < nstop; s++) drive(w, stops[s], ST);
    endtask

    vec_t tv_def[5];
    vec_t tv_par[4];
    vec_t tv_stp[4];

    initial begin
        tv_def[0] = '{8'hA5, 1'b0, 2'b11, '{8'hA5, 1'b0, 1'b0, 1'b0}};
        tv_def[1] = '{8'h55, 1'b0, 2'b10, '{8'h55, 1'b1, 1'b0, 1'b0}};
        tv_def[2] = '{8'h00, 1'b0, 2'b00, '{8'h00, 1'b1, 1'b0, 1'b1}};
        tv_def[3] = '{8'hFF, 1'b0, 2'b11, '{8'hFF, 1'b0, 1'b0, 1'b0}};
        tv_def[4] = '{8'h3C, 1'b0, 2'b11, '{8'h3C, 1'b0, 1'b0, 1'b0}};
        tv_par[0] = '{8'h3C, 1'b1, 2'b11, '{8'h3C, 1'b0, 1'b1, 1'b0}};
        tv_par[1] = '{8'h3C, 1'b0, 2'b11, '{8'h3C, 1'b0, 1'b0, 1'b0}};
        tv_par[2] = '{8'h01, 1'b1, 2'b11, '{8'h01, 1'b0, 1'b0, 1'b0}};
        tv_par[3] = '{8'h00, 1'b0, 2'b00, '{8'h00, 1'b1, 1'b0, 1'b1}};
        tv_stp[0] = '{8'h01, 1'b0, 2'b11, '{8'h01, 1'b0, 1'b0, 1'b0}};
        tv_stp[1] = '{8'h80, 1'b0, 2'b11, '{8'h80, 1'b0, 1'b0, 1'b0}};
        tv_stp[2] = '{8'hFF, 1'b0, 2'b11, '{8'hFF, 1'b0, 1'b0, 1'b0}};
        tv_stp[3] = '{8'h12, 1'b0, 2'b10, '{8'h12, 1'b1, 1'b0, 1'b0}};

        reset_n = 1'b0;
        s_tick  = 1'b1;
        rx_def  = 1'b1;
        rx_par  = 1'b1;
        rx_stp  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset data", 16'(data_def), 16'h0);
        chk("reset done", 16'(done_def), 16'h0);
        chk("reset frame_error", 16'(fe_def), 16'h0);
        chk("reset parity_error", 16'(pe_par), 16'h0);
        chk("reset break", 16'(brk_stp), 16'h0);
        reset_n = 1'b1;
        drive(0, 1'b1, 20);

        for (int i = 0; i < 5; i++) begin
            push(0, tv_def[i].e);
            send_frame(0, tv_def[i].d, 1'b0, 1'b0, tv_def[i].stops, 1, -1);
            drive(0, 1'b1, 2 * ST);
        end
        chk("sticky data", 16'(data_def), 16'h3C);
        chk("sticky frame_error", 16'(fe_def), 16'h0);

        drive(0, 1'b0, ST / 4);
        drive(0, 1'b1, 3 * ST);
        chk("glitch rejected", 16'(n_done[0]), 16'(n_exp[0]));

        drive(0, 1'b0, ST);
        for (int i = 0; i < 4; i++) drive(0, i[0], ST);
        reset_n = 1'b0;
        rx_def  = 1'b1;
        @(negedge clk);
        chk("midframe reset data", 16'(data_def), 16'h0);
        chk("midframe reset done", 16'(done_def), 16'h0);
        reset_n = 1'b1;
        drive(0, 1'b1, 3 * ST);
        chk("midframe reset no done", 16'(n_done[0]), 16'(n_exp[0]));
        push(0, '{8'hC3, 1'b0, 1'b0, 1'b0});
        send_frame(0, 8'hC3, 1'b0, 1'b0, 2'b11, 1, -1);
        drive(0, 1'b1, 2 * ST);

        for (int i = 0; i < 4; i++) begin
            push(1, tv_par[i].e);
            send_frame(1, tv_par[i].d, 1'b1, tv_par[i].pb, tv_par[i].stops, 1, -1);
            drive(1, 1'b1, 2 * ST);
        end
        chk("sticky break", 16'(brk_par), 16'h1);

        for (int i = 0; i < 3; i++) begin
            push(2, tv_stp[i].e);
            send_frame(2, tv_stp[i].d, 1'b0, 1'b0, tv_stp[i].stops, 2, -1);
        end
        drive(2, 1'b1, 2 * ST);
        push(2, tv_stp[3].e);
        send_frame(2, tv_stp[3].d, 1'b0, 1'b0, tv_stp[3].stops, 2, -1);
        drive(2, 1'b1, 2 * ST);

`ifdef UART_RX_MAJORITY_EN
        push(0, '{8'hA5, 1'b0, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1, 3);
        drive(0, 1'b1, 2 * ST);
`endif

        chk("dut0 done count", 16'(n_done[0]), 16'(n_exp[0]));
        chk("dut1 done count", 16'(n_done[1]), 16'(n_exp[1]));
        chk("dut2 done count", 16'(n_done[2]), 16'(n_exp[2]));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
